// File: rtl/clk_unit.sv
// clk_unit: machine-cycle timing generator for the 8051-compatible core.
// Divides the oscillator clock into 12 slots (S1P1..S6P2) and decodes the
// Phase, ALE and PSEN strobes from the slot counter. A MOVX opcode seen at
// the end of a normal cycle stretches the instruction by one extra cycle
// (c2), during which the S1 ALE pulse and both PSEN pulses are suppressed.
// Optional feature macro: CLKU_STATE_OUT_EN adds the State/Cycle2 outputs.
module clk_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic       EA,
    input  logic [7:0] IR,
    output logic       Phase,
    output logic       ALE,
    output logic       PSEN
`ifdef CLKU_STATE_OUT_EN
   ,output logic [2:0] State,
    output logic [0:0] Cycle2
`endif
);

    localparam logic [3:0] LAST_SLOT = 4'd11;

    logic [3:0] t_q, t_d;
    logic       c2_q, c2_d;
    logic       is_movx;

    // MOVX opcodes: E0,E2,E3,F0,F2,F3; E1/F1 are AJMP/ACALL and excluded
    always_comb begin
        is_movx = 1'b0;
        case (IR)
            8'hE0, 8'hE2, 8'hE3, 8'hF0, 8'hF2, 8'hF3: is_movx = 1'b1;
            default:                                  is_movx = 1'b0;
        endcase
    end

    // Next slot and c2 flag; IR only matters on the last slot of a normal cycle
    always_comb begin
        t_d  = (t_q == LAST_SLOT) ? 4'd0 : t_q + 4'd1;
        c2_d = c2_q;
        if (t_q == LAST_SLOT) begin
            c2_d = c2_q ? 1'b0 : is_movx;
        end
    end

    // Slot counter and second-cycle flag; reset restarts at S1P1 of a first cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            t_q  <= 4'd0;
            c2_q <= 1'b0;
        end else begin
            t_q  <= t_d;
            c2_q <= c2_d;
        end
    end

    // Strobe decode from registered slot/c2 and the live EA pin
    always_comb begin
        Phase = t_q[0];
        ALE   = (((t_q == 4'd1) || (t_q == 4'd2)) && !c2_q) ||
                (t_q == 4'd7) || (t_q == 4'd8);
        PSEN  = !(!EA && !c2_q &&
                  (((t_q >= 4'd3) && (t_q <= 4'd5)) ||
                   ((t_q >= 4'd9) && (t_q <= 4'd11))));
    end

`ifdef CLKU_STATE_OUT_EN
    // Current Sx (1..6) and second-cycle indicator for debug/observability
    always_comb begin
        State  = t_q[3:1] + 3'd1;
        Cycle2 = c2_q;
    end
`endif

endmodule

// File: tb/tb_clk_unit.sv
// tb_clk_unit: directed, table-driven bench for clk_unit. Each table row is
// one 12-clock machine cycle with hand-computed per-slot ALE/PSEN masks.
module tb_clk_unit;

    logic       clk;
    logic       reset;
    logic       EA;
    logic [7:0] IR;
    logic       Phase, ALE, PSEN;
`ifdef CLKU_STATE_OUT_EN
    logic [2:0] State;
    logic [0:0] Cycle2;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    clk_unit dut (
        .clk   (clk),
        .reset (reset),
        .EA    (EA),
        .IR    (IR),
        .Phase (Phase),
        .ALE   (ALE),
        .PSEN  (PSEN)
`ifdef CLKU_STATE_OUT_EN
       ,.State (State),
        .Cycle2(Cycle2)
`endif
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    typedef struct {
        logic        ea;
        logic [7:0]  ir;
        logic        c2;     // expected: this cycle is a MOVX second cycle
        logic [11:0] ale;    // expected ALE per slot (bit n = slot n)
        logic [11:0] psen;   // expected PSEN per slot
    } vec_t;

    localparam logic [11:0] ALE_N  = 12'h186;  // slots 1,2,7,8
    localparam logic [11:0] ALE_C2 = 12'h180;  // slots 7,8
    localparam logic [11:0] PS_ON  = 12'h1C7;  // low in 3-5, 9-11
    localparam logic [11:0] PS_OFF = 12'hFFF;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Check the current 12 slots against a row, advancing one clock per slot
    task automatic run_cycle(input int row, input vec_t v);
        EA = v.ea;
        IR = v.ir;
        for (int s = 0; s < 12; s++) begin
            chk($sformatf("row%0d slot%0d Phase", row, s), {7'd0, Phase}, {7'd0, s[0]});
            chk($sformatf("row%0d slot%0d ALE", row, s), {7'd0, ALE}, {7'd0, v.ale[s]});
            chk($sformatf("row%0d slot%0d PSEN", row, s), {7'd0, PSEN}, {7'd0, v.psen[s]});
`ifdef CLKU_STATE_OUT_EN
            chk($sformatf("row%0d slot%0d State", row, s), {5'd0, State}, 8'(s / 2 + 1));
            chk($sformatf("row%0d slot%0d Cycle2", row, s), {7'd0, Cycle2}, {7'd0, v.c2});
`endif
            @(posedge clk); #10;
        end
    endtask

    initial begin
        vecs[0]  = '{1'b0, 8'h00, 1'b0, ALE_N,  PS_ON};
        vecs[1]  = '{1'b0, 8'h00, 1'b0, ALE_N,  PS_ON};
        vecs[2]  = '{1'b0, 8'hF0, 1'b0, ALE_N,  PS_ON};
        vecs[3]  = '{1'b0, 8'hF0, 1'b1, ALE_C2, PS_OFF};
        vecs[4]  = '{1'b0, 8'hF0, 1'b0, ALE_N,  PS_ON};
        vecs[5]  = '{1'b0, 8'hF0, 1'b1, ALE_C2, PS_OFF};
        vecs[6]  = '{1'b1, 8'hF0, 1'b0, ALE_N,  PS_OFF};
        vecs[7]  = '{1'b1, 8'hF0, 1'b1, ALE_C2, PS_OFF};
        vecs[8]  = '{1'b1, 8'hE3, 1'b0, ALE_N,  PS_OFF};
        vecs[9]  = '{1'b1, 8'hE3, 1'b1, ALE_C2, PS_OFF};
        vecs[10] = '{1'b1, 8'hE1, 1'b0, ALE_N,  PS_OFF};
        vecs[11] = '{1'b1, 8'hE1, 1'b0, ALE_N,  PS_OFF};
        vecs[12] = '{1'b0, 8'hE2, 1'b0, ALE_N,  PS_ON};
        vecs[13] = '{1'b0, 8'hE2, 1'b1, ALE_C2, PS_OFF};
        vecs[14] = '{1'b0, 8'hF1, 1'b0, ALE_N,  PS_ON};
        vecs[15] = '{1'b0, 8'hF3, 1'b0, ALE_N,  PS_ON};
        vecs[16] = '{1'b0, 8'hE4, 1'b1, ALE_C2, PS_OFF};
        vecs[17] = '{1'b0, 8'hD0, 1'b0, ALE_N,  PS_ON};
        vecs[18] = '{1'b0, 8'hE0, 1'b0, ALE_N,  PS_ON};
        vecs[19] = '{1'b0, 8'h00, 1'b1, ALE_C2, PS_OFF};

        // Reset held over 3 edges: idle strobes throughout
        reset = 1'b1;
        EA    = 1'b0;
        IR    = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #10;
            chk($sformatf("reset%0d Phase", i), {7'd0, Phase}, 8'd0);
            chk($sformatf("reset%0d ALE", i), {7'd0, ALE}, 8'd0);
            chk($sformatf("reset%0d PSEN", i), {7'd0, PSEN}, 8'd1);
        end
        reset = 1'b0;

        for (int r = 0; r < 20; r++) run_cycle(r, vecs[r]);

        // Mid-cycle reset in a MOVX second cycle
        run_cycle(100, '{1'b0, 8'hF0, 1'b0, ALE_N, PS_ON});
        IR = 8'h00;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #10;
        end
        chk("c2 slot6 PSEN", {7'd0, PSEN}, 8'd1);
        chk("c2 slot6 ALE", {7'd0, ALE}, 8'd0);
        reset = 1'b1;
        @(posedge clk); #10;
        reset = 1'b0;
        chk("midreset Phase", {7'd0, Phase}, 8'd0);
        chk("midreset ALE", {7'd0, ALE}, 8'd0);
        chk("midreset PSEN", {7'd0, PSEN}, 8'd1);
`ifdef CLKU_STATE_OUT_EN
        chk("midreset State", {5'd0, State}, 8'd1);
        chk("midreset Cycle2", {7'd0, Cycle2}, 8'd0);
`endif
        run_cycle(101, '{1'b0, 8'h00, 1'b0, ALE_N, PS_ON});
        run_cycle(102, '{1'b0, 8'h00, 1'b0, ALE_N, PS_ON});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
